omsp_spm_layout_reader: RTL
===========================

# omsp_spm_layout_reader

Sequencing read master for the protected-module data-select port. On a `start` request it selects one protected module by ID or by address, then walks `data_request` through a fixed range of layout/ID words. Each `requested_data` word is captured and streamed to a downstream consumer (attestation/hash engine, debug unit) over a valid/ready handshake. It drives the select/request side of the protected-module controller and consumes its `spm_data_select_valid` / `requested_data` responses.

## Interface
- `NB_REQ`, 5: number of words read per transaction; legal 1..8.
- `FIRST_REQ`, 0: `data_request` code of the first word; `FIRST_REQ+NB_REQ-1` ≤ 7.
- `mclk`  in  1  clock.
- `puc_rst`  in  1  reset; synchronous, active-high (sampled on `mclk` rising edge only).
- `start`  in  1  transaction request; sampled only in IDLE.
- `sel`  in  16  module selector (ID or address), latched on accepted `start`.
- `sel_type`  in  1  selector type, latched with `sel`.
- `abort`  in  1  cancel current transaction.
- `spm_data_select`  out  16  latched `sel` while busy; 0 in IDLE.
- `spm_data_select_type`  out  1  latched `sel_type` while busy; 0 in IDLE.
- `data_request`  out  3  `FIRST_REQ+idx` in READ/EMIT; 0 otherwise.
- `spm_data_select_valid`  in  1  controller: selector matches an enabled module (combinational from selects).
- `requested_data`  in  16  controller: selected word (combinational from selects/request).
- `out_valid`  out  1  `out_data` holds a word.
- `out_data`  out  16  captured word.
- `out_last`  out  1  high with `out_valid` on final word.
- `out_ready`  in  1  consumer accepts word.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse: all words delivered.
- `error`  out  1  one-cycle pulse: selection invalid at lookup or during read.

## Operation
- States: IDLE, LOOKUP, READ, EMIT. `idx` is a 3-bit counter in 0..NB_REQ-1.
- Reset: state IDLE, `idx`=0, all outputs 0, latched `sel`/`sel_type` = 0.
- IDLE: `start`=1 → latch `sel`/`sel_type`, `idx`←0, go to LOOKUP. `done`/`error` are cleared every cycle unless set by a transition.
- LOOKUP: selects are driven from registers. `spm_data_select_valid`=1 → READ. Otherwise → IDLE with `error` pulsed.
- READ: `data_request`=`FIRST_REQ+idx`. If `spm_data_select_valid`=1 → capture `requested_data` into `out_data`, set `out_valid`, set `out_last`=(idx==NB_REQ-1), go to EMIT. Otherwise (module disabled mid-transaction) → IDLE with `error` pulsed and no word emitted.
- EMIT: `out_valid`, `out_data` and `out_last` hold stable until `out_ready`=1.
  - On handshake with `out_last` → IDLE, `done` pulsed.
  - On handshake otherwise → `idx`+1, go to READ.
  - `out_valid` drops on the cycle after handshake.
- `abort`=1 in any non-IDLE state → IDLE next cycle; `out_valid` cleared; no `done`/`error`. `abort` in IDLE is ignored.
- Priority per cycle: `puc_rst` > `abort` > state transition.
- `start` while busy is ignored. It is not queued.
- `done` and `error` are mutually exclusive and never overlap `busy`.

## Timing
- All outputs are registered; no combinational input→output path.
- `start` accepted at edge T: LOOKUP during T+1, READ during T+2, first `out_valid` at T+3.
- With `out_ready` held high, the throughput is one word per 2 cycles. A transaction occupies 2·NB_REQ+1 busy cycles, and `done` asserts in the cycle after the last handshake, with `busy`=0.
- Invalid selection: `error` asserts 2 cycles after `start` (first IDLE cycle); `busy` is high for 1 cycle.
- A new `start` may be accepted in the same cycle that `done`/`error` is high.
- `puc_rst` mid-transaction: next cycle all outputs are 0, with no `done`/`error` pulse.

## Test plan
- Valid module, `sel`=16'h0003, `sel_type`=0, `out_ready`=1, NB_REQ=5 → 5 words with `data_request` 0,1,2,3,4 and `out_data` matching the model per code, `out_last` on word 5 only, `done` at start+12, 11 busy cycles.
- Non-matching selector (`spm_data_select_valid`=0) → `error` pulse 2 cycles after `start`, no `out_valid`, `busy` for 1 cycle.
- Backpressure: `out_ready`=0 for 4 cycles on word 2 → `out_valid`/`out_data`/`data_request` stable throughout, word 3 follows 2 cycles after release.
- Module disabled (valid→0) while in EMIT for word 1 → word 1 completes, next READ pulses `error`, no `done`.
- `abort` during EMIT of word 3 → `busy`/`out_valid` 0 next cycle, no pulses. `start` during busy → ignored.
- `puc_rst` asserted in READ → all outputs 0 at next edge. Back-to-back `start` in the `done` cycle → second transaction starts immediately.

Source files
------------

// File: rtl/omsp_spm_layout_reader.sv
// rtl/omsp_spm_layout_reader.sv - sequencing read master for the protected-module data-select port
module omsp_spm_layout_reader #(
  parameter int NB_REQ    = 5,
  parameter int FIRST_REQ = 0
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        start,
  input  logic [15:0] sel,
  input  logic        sel_type,
  input  logic        abort,
  output logic [15:0] spm_data_select,
  output logic        spm_data_select_type,
  output logic [2:0]  data_request,
  input  logic        spm_data_select_valid,
  input  logic [15:0] requested_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] FIRST_L  = 3'(FIRST_REQ);
  localparam logic [2:0] LAST_IDX = 3'(NB_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_READ, S_EMIT} state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [15:0] sel_q;
  logic        sel_type_q;
  logic [2:0]  data_request_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic        out_last_q;
  logic        done_q;
  logic        error_q;

  logic to_idle;
  logic set_done;
  logic set_error;

  // Every way back to IDLE funnels through here so the clear-down is identical for all of them.
  always_comb begin
    to_idle   = 1'b0;
    set_done  = 1'b0;
    set_error = 1'b0;
    if (state_q != S_IDLE) begin
      if (abort) begin
        to_idle = 1'b1;
      end else begin
        case (state_q)
          S_LOOKUP, S_READ: begin
            if (!spm_data_select_valid) begin
              to_idle   = 1'b1;
              set_error = 1'b1;
            end
          end
          S_EMIT: begin
            if (out_ready && out_last_q) begin
              to_idle  = 1'b1;
              set_done = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q        <= S_IDLE;
      idx_q          <= 3'd0;
      sel_q          <= 16'h0000;
      sel_type_q     <= 1'b0;
      data_request_q <= 3'd0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 16'h0000;
      out_last_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      done_q  <= set_done;
      error_q <= set_error;
      if (to_idle) begin
        state_q        <= S_IDLE;
        idx_q          <= 3'd0;
        sel_q          <= 16'h0000;
        sel_type_q     <= 1'b0;
        data_request_q <= 3'd0;
        out_valid_q    <= 1'b0;
        out_data_q     <= 16'h0000;
        out_last_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_LOOKUP;
              sel_q      <= sel;
              sel_type_q <= sel_type;
              idx_q      <= 3'd0;
            end
          end
          S_LOOKUP: begin
            state_q        <= S_READ;
            data_request_q <= FIRST_L;
          end
          S_READ: begin
            state_q     <= S_EMIT;
            out_data_q  <= requested_data;
            out_valid_q <= 1'b1;
            out_last_q  <= (idx_q == LAST_IDX);
          end
          S_EMIT: begin
            // The final handshake is taken by to_idle, so this only advances to the next word.
            if (out_ready) begin
              state_q        <= S_READ;
              out_valid_q    <= 1'b0;
              out_last_q     <= 1'b0;
              idx_q          <= idx_q + 3'd1;
              data_request_q <= FIRST_L + idx_q + 3'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign spm_data_select      = sel_q;
  assign spm_data_select_type = sel_type_q;
  assign data_request         = data_request_q;
  assign out_valid            = out_valid_q;
  assign out_data             = out_data_q;
  assign out_last             = out_last_q;
  assign busy                 = (state_q != S_IDLE);
  assign done                 = done_q;
  assign error                = error_q;

endmodule
